qeciphy_crc16_checker: RTL and testbench

// Receive-side CRC-16/IBM-3740 checker, the counterpart of the TX CRC generator on the 64-bit link datapath.
// - Tracks framing: PAYLOAD_WORDS payload words followed by one trailer word.
// - Computes the CRC over the payload and compares it with the CRC carried in the trailer.
// - Reports a per-frame pass/fail result and keeps error/frame statistics for link-quality monitoring.

---
 rtl/qeciphy_crc16_checker.sv | 131 +++++++++++++
 tb/tb_qeciphy_crc16_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qeciphy_crc16_checker.sv
// Receive-side CRC-16/IBM-3740 checker for the 64-bit link datapath.
// Frames are PAYLOAD_WORDS payload words plus one trailer word carrying the CRC in [15:0].
module qeciphy_crc16_checker #(
  parameter int PAYLOAD_WORDS = 7,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      i_data,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic             i_clear_counts,
  output logic             o_done,
  output logic             o_crc_ok,
  output logic [15:0]      o_calc_crc,
  output logic [15:0]      o_rx_crc,
  output logic             o_sof_err,
  output logic [CNT_W-1:0] o_frame_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int                  CNT_BITS     = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [CNT_BITS-1:0] LAST_PAYLOAD = CNT_BITS'(PAYLOAD_WORDS - 1);
  localparam logic [15:0]         CRC_INIT     = 16'hFFFF;

  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_TRAILER} state_t;

  state_t              r_state, w_next_state;
  logic [15:0]         r_crc, w_crc_next;
  logic [CNT_BITS-1:0] r_cnt;
  logic                w_start, w_payload_acc, w_trailer_acc, w_resync;
  logic                r_done, r_crc_ok, r_sof_err;
  logic [15:0]         r_calc_crc, r_rx_crc;
  logic [CNT_W-1:0]    r_frame_count, r_err_count;

  // Bit-serial MSB-first definition; the loop unrolls into one level of XOR equations.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [63:0] data);
    logic [15:0] c;
    logic        fb;
    // NOTE: blocking assignments inside a function/always_comb model combinational chains;
    // registered state is only ever updated with <= in always_ff.
    c = crc_in;
    for (int i = 63; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_next_state = r_state;
    if (w_start) begin
      if (PAYLOAD_WORDS == 1) w_next_state = ST_TRAILER;
      else                    w_next_state = ST_PAYLOAD;
    end else if (w_payload_acc && (r_cnt == LAST_PAYLOAD)) begin
      w_next_state = ST_TRAILER;
    end else if (w_trailer_acc) begin
      w_next_state = ST_IDLE;
    end
  end

  // An i_sof word always restarts a frame, whatever state it arrives in.
  always_comb begin
    w_start       = i_valid & i_sof;
    w_payload_acc = i_valid & ~i_sof & (r_state == ST_PAYLOAD);
    w_trailer_acc = i_valid & ~i_sof & (r_state == ST_TRAILER);
    w_resync      = w_start & (r_state != ST_IDLE);
    w_crc_next    = crc16_word(w_start ? CRC_INIT : r_crc, i_data);
  end

  always_ff @(posedge clk) begin
    // NOTE: every register here has an explicit reset value; there is no storage array to leave unreset.
    if (rst) begin
      r_crc <= CRC_INIT;
      r_cnt <= '0;
    end else if (w_start) begin
      r_crc <= w_crc_next;
      r_cnt <= CNT_BITS'(1);
    end else if (w_payload_acc) begin
      r_crc <= w_crc_next;
      r_cnt <= r_cnt + 1'b1;
    end else if (w_trailer_acc) begin
      r_crc <= CRC_INIT;
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_crc_ok   <= 1'b0;
      r_sof_err  <= 1'b0;
      r_calc_crc <= CRC_INIT;
      r_rx_crc   <= '0;
    end else begin
      r_done    <= w_trailer_acc;
      r_crc_ok  <= w_trailer_acc & (r_crc == i_data[15:0]);
      r_sof_err <= w_resync;
      if (w_trailer_acc) begin
        r_calc_crc <= r_crc;
        r_rx_crc   <= i_data[15:0];
      end
    end
  end

  // Statistics follow the o_done pulse; a same-cycle clear wins.
  always_ff @(posedge clk) begin
    if (rst || i_clear_counts) begin
      r_frame_count <= '0;
      r_err_count   <= '0;
    end else if (r_done) begin
      if (r_frame_count != '1)             r_frame_count <= r_frame_count + 1'b1;
      if (!r_crc_ok && r_err_count != '1) r_err_count   <= r_err_count + 1'b1;
    end
  end

  assign o_done        = r_done;
  assign o_crc_ok      = r_crc_ok;
  assign o_calc_crc    = r_calc_crc;
  assign o_rx_crc      = r_rx_crc;
  assign o_sof_err     = r_sof_err;
  assign o_frame_count = r_frame_count;
  assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_qeciphy_crc16_checker.sv
// Bench for qeciphy_crc16_checker: frame-level reference model (table-driven byte CRC over
// buffered payload words) compared every cycle, plus directed literal expectations.
module tb_qeciphy_crc16_checker;

  localparam int P     = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef logic [7:0] bq_t[$];
  typedef logic [63:0] wq_t[$];

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [63:0]      i_data = '0;
  logic             i_valid = 1'b0;
  logic             i_sof = 1'b0;
  logic             i_clear_counts = 1'b0;
  logic             o_done, o_crc_ok, o_sof_err;
  logic [15:0]      o_calc_crc, o_rx_crc;
  logic [CNT_W-1:0] o_frame_count, o_err_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done_seen = 0;
  int n_sof_seen  = 0;

  logic [15:0] crc_tab [0:255];

  // Model state: buffered frame words and the outputs expected after each clock edge.
  wq_t         m_words;
  logic        m_done = 1'b0, m_ok = 1'b0, m_sof_err = 1'b0;
  logic [15:0] m_calc = 16'hFFFF, m_rx = 16'h0000;
  int          m_fc = 0, m_ec = 0;

  qeciphy_crc16_checker #(.PAYLOAD_WORDS(P), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_sof(i_sof),
    .i_clear_counts(i_clear_counts), .o_done(o_done), .o_crc_ok(o_crc_ok),
    .o_calc_crc(o_calc_crc), .o_rx_crc(o_rx_crc), .o_sof_err(o_sof_err),
    .o_frame_count(o_frame_count), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_bytes(input bq_t b);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[k]) c = {c[7:0], 8'h00} ^ crc_tab[c[15:8] ^ b[k]];
    return c;
  endfunction

  function automatic logic [15:0] crc_words(input wq_t w);
    bq_t b;
    foreach (w[k]) for (int j = 7; j >= 0; j--) b.push_back(w[k][j*8 +: 8]);
    return crc_bytes(b);
  endfunction

  function automatic logic [15:0] crc_pair(input logic [63:0] w0, input logic [63:0] w1);
    wq_t w;
    w.push_back(w0);
    w.push_back(w1);
    return crc_words(w);
  endfunction

  // Model: at each edge, predict the registered outputs from the sampled inputs.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_words.delete();
      m_done = 0; m_ok = 0; m_sof_err = 0;
      m_calc = 16'hFFFF; m_rx = 16'h0000; m_fc = 0; m_ec = 0;
    end else begin
      if (i_clear_counts) begin
        m_fc = 0; m_ec = 0;
      end else if (m_done) begin
        if (m_fc < CMAX) m_fc++;
        if (!m_ok && m_ec < CMAX) m_ec++;
      end
      m_done = 0; m_sof_err = 0;
      if (i_valid) begin
        if (i_sof) begin
          m_sof_err = (m_words.size() != 0);
          m_words.delete();
          m_words.push_back(i_data);
        end else if (m_words.size() == P) begin
          m_calc = crc_words(m_words);
          m_rx   = i_data[15:0];
          m_done = 1;
          m_ok   = (m_calc == m_rx);
          m_words.delete();
        end else if (m_words.size() != 0) begin
          m_words.push_back(i_data);
        end
      end
    end
    @(negedge clk);
    check("done", o_done, m_done);
    check("sof_err", o_sof_err, m_sof_err);
    check("calc_crc", o_calc_crc, m_calc);
    check("rx_crc", o_rx_crc, m_rx);
    check("frame_count", o_frame_count, m_fc);
    check("err_count", o_err_count, m_ec);
    if (m_done) check("crc_ok", o_crc_ok, m_ok);
    if (o_done) n_done_seen++;
    if (o_sof_err) n_sof_seen++;
  end

  task automatic cycle(input logic v, input logic s, input logic [63:0] d, input logic clr);
    i_valid = v; i_sof = s; i_data = d; i_clear_counts = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int max_gap);
    int n;
    n = $urandom_range(max_gap, 0);
    repeat (n) cycle(1'b0, 1'($urandom_range(1, 0)), {$urandom(), $urandom()}, 1'b0);
  endtask

  // Returns #1 after the edge that accepts the trailer, i.e. while o_done is high.
  task automatic send_frame(input logic [63:0] w0, input logic [63:0] w1,
                            input logic [15:0] trl, input int max_gap);
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    t[15:0] = trl;
    cycle(1'b1, 1'b1, w0, 1'b0);
    gap(max_gap);
    cycle(1'b1, 1'b0, w1, 1'b0);
    gap(max_gap);
    cycle(1'b1, 1'b0, t, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  initial begin
    bq_t         s;
    bq_t         r;
    logic [15:0] g, c14;
    logic [63:0] a, b, w0;
    logic [47:0] hi;
    int          d0, s0;

    for (int n = 0; n < 256; n++) begin
      logic [15:0] c;
      c = 16'(n) << 8;
      repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      crc_tab[n] = c;
    end

    // Pin the model against well-known CRC-16/IBM-3740 values.
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_123456789", crc_bytes(s), 16'h29B1);
    s = '{8'h00};
    check("model_byte_00", crc_bytes(s), 16'hE1F0);

    // Reset, with activity on the inputs.
    rst = 1'b1;
    cycle(1'b1, 1'b1, 64'h1234, 1'b0);
    cycle(1'b1, 1'b0, 64'h5678, 1'b0);
    rst = 1'b0;
    idle(1);
    check("rst_calc_crc", o_calc_crc, 16'hFFFF);
    check("rst_rx_crc", o_rx_crc, 16'h0000);
    check("rst_done", o_done, 1'b0);
    check("rst_frame_count", o_frame_count, 0);

    // Stray non-SOF words in IDLE are dropped, then the all-zero good frame.
    cycle(1'b1, 1'b0, 64'hDEAD_BEEF_0000_FFFF, 1'b0);
    cycle(1'b1, 1'b0, 64'h0, 1'b0);
    g = crc_pair(64'h0, 64'h0);
    send_frame(64'h0, 64'h0, g, 0);
    check("zero_done", o_done, 1'b1);
    check("zero_ok", o_crc_ok, 1'b1);
    idle(1);
    check("zero_frame_count", o_frame_count, 1);
    check("zero_err_count", o_err_count, 0);

    // Same frame with trailer bit 0 flipped.
    send_frame(64'h0, 64'h0, g ^ 16'h0001, 1);
    check("flip_done", o_done, 1'b1);
    check("flip_ok", o_crc_ok, 1'b0);
    check("flip_rx_crc", o_rx_crc, g ^ 16'h0001);
    idle(1);
    check("flip_err_count", o_err_count, 1);
    check("flip_frame_count", o_frame_count, 2);

    // Residue frame: trailer CRC embedded in the payload makes the whole-frame CRC zero.
    w0 = 64'h0123_4567_89AB_CDEF;
    hi = 48'hFEDC_BA98_7654;
    r.delete();
    for (int j = 7; j >= 0; j--) r.push_back(w0[j*8 +: 8]);
    for (int j = 5; j >= 0; j--) r.push_back(hi[j*8 +: 8]);
    c14 = crc_bytes(r);
    send_frame(w0, {hi, c14}, 16'h0000, 0);
    check("residue_done", o_done, 1'b1);
    check("residue_calc_crc", o_calc_crc, 16'h0000);
    check("residue_ok", o_crc_ok, 1'b1);

    // 100 frames, random payloads and gaps, every 10th trailer corrupted.
    idle(2);
    cycle(1'b0, 1'b0, 64'h0, 1'b1);
    d0 = n_done_seen;
    for (int i = 1; i <= 100; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      g = crc_pair(a, b);
      if (i % 10 == 0) g ^= 16'(1 << $urandom_range(15, 0));
      send_frame(a, b, g, 3);
      gap(3);
    end
    idle(2);
    check("burst_done_pulses", n_done_seen - d0, 100);
    check("burst_err_count", o_err_count, 10);
    check("burst_frame_count_sat", o_frame_count, CMAX);

    // Resync: SOF on payload word 1, and SOF in the trailer slot; one good frame results.
    d0 = n_done_seen;
    s0 = n_sof_seen;
    a = 64'hAAAA_5555_0F0F_F0F0;
    b = 64'h1111_2222_3333_4444;
    cycle(1'b1, 1'b1, 64'h9999, 1'b0);
    send_frame(a, b, crc_pair(a, b), 0);
    check("resync1_ok", o_crc_ok, 1'b1);
    cycle(1'b1, 1'b1, 64'h7777, 1'b0);
    cycle(1'b1, 1'b0, 64'h8888, 1'b0);
    send_frame(b, a, crc_pair(b, a), 2);
    check("resync2_ok", o_crc_ok, 1'b1);
    idle(2);
    check("resync_sof_err_pulses", n_sof_seen - s0, 2);
    check("resync_done_pulses", n_done_seen - d0, 2);

    // Reset mid-payload, then a good frame.
    cycle(1'b1, 1'b1, a, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 1'b0, b, 1'b0);
    rst = 1'b0;
    check("midrst_calc_crc", o_calc_crc, 16'hFFFF);
    check("midrst_rx_crc", o_rx_crc, 16'h0000);
    check("midrst_frame_count", o_frame_count, 0);
    check("midrst_err_count", o_err_count, 0);
    d0 = n_done_seen;
    idle(1);
    cycle(1'b1, 1'b0, a, 1'b0);
    send_frame(b, a, crc_pair(b, a), 1);
    check("postrst_ok", o_crc_ok, 1'b1);
    idle(1);
    check("postrst_done_pulses", n_done_seen - d0, 1);
    check("postrst_frame_count", o_frame_count, 1);

    // Saturation: 20 bad frames on 4-bit counters.
    cycle(1'b0, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      a = {$urandom(), $urandom()};
      send_frame(a, ~a, crc_pair(a, ~a) ^ 16'h8000, 1);
    end
    idle(2);
    check("sat_err_count", o_err_count, CMAX);
    check("sat_frame_count", o_frame_count, CMAX);

    // Clear on the same cycle as o_done wins over the increment.
    send_frame(a, b, crc_pair(a, b) ^ 16'h0100, 0);
    check("clr_done_high", o_done, 1'b1);
    cycle(1'b0, 1'b0, 64'h0, 1'b1);
    check("clr_frame_count", o_frame_count, 0);
    check("clr_err_count", o_err_count, 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
